mc_ctrl: RTL
============

# mc_ctrl

Multi-cycle control unit for the MIPS CPU. It sequences the shared datapath (PC/NPC, IR, GRF, ALU, DM, immediate extender) through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states. Each cycle it drives every write enable and mux select, including the extender's `EOp`. It replaces the single-cycle combinational controller, so one ALU, one extender and one memory port are reused across the cycles of each instruction.

## Interface
Parameters:
- none (all encodings are fixed in the package)

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: IR[31:26], valid from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU equality flag.
- `PCWr` out 1: PC load enable.
- `IRWr` out 1: IR load enable.
- `RFWr` out 1: GRF write enable.
- `DMWr` out 1: data memory write enable.
- `EOp` out 2: extender mode. 00 = sign, 01 = zero, 10 = lui, 11 = sign<<2.
- `ALUOp` out 3: 000 = add, 001 = sub, 010 = or.
- `ALUSrc` out 1: 0 = rt data, 1 = ext.
- `RegDst` out 2: 00 = rt, 01 = rd, 10 = $31.
- `WDSel` out 2: 00 = ALU result, 01 = DM read data, 10 = PC.
- `NPCOp` out 2: 00 = PC+4, 01 = PC + ext, 10 = {PC[31:28], imm26, 00}, 11 = rs data.
- `state` out 3: current state, for debug and bench.

## Operation
- States: FETCH = 0, DCD = 1, EXE = 2, MEM = 3, WB = 4, BR = 5. Encodings 6 and 7 are illegal and return to FETCH on the next edge.
- The only storage is the state register. All outputs are combinational from `state`, `op`, `funct` and `zero`.
- Outputs not listed for a state are 0. Selects not listed are 00/0.
- FETCH:
  - IRWr = 1, PCWr = 1, NPCOp = 00.
  - Next state: DCD.
- DCD, by instruction class:
  - R-type addu (funct 100001) or subu (100011): next EXE.
  - ori (001101), lui (001111), lw (100011), sw (101011): next EXE.
  - beq (000100): next BR.
  - j (000010): PCWr = 1, NPCOp = 10; next FETCH.
  - jal (000011): as j, plus RFWr = 1, RegDst = 10, WDSel = 10 (PC already holds PC+4); next FETCH.
  - jr (R, funct 001000): PCWr = 1, NPCOp = 11; next FETCH.
  - Unknown op/funct, including nop: no writes; next FETCH.
- EXE:
  - addu: ALUOp = 000, ALUSrc = 0.
  - subu: ALUOp = 001, ALUSrc = 0.
  - ori: ALUOp = 010, ALUSrc = 1, EOp = 01.
  - lui: ALUOp = 000, ALUSrc = 1, EOp = 10 (the rs operand is ignored by the datapath).
  - lw/sw: ALUOp = 000, ALUSrc = 1, EOp = 00.
  - Next state: MEM for lw/sw, WB for all others.
- MEM:
  - sw: DMWr = 1; next FETCH.
  - lw: no writes; next WB.
- WB:
  - RFWr = 1.
  - R-type: RegDst = 01, WDSel = 00.
  - ori/lui: RegDst = 00, WDSel = 00.
  - lw: RegDst = 00, WDSel = 01.
  - Next state: FETCH.
- BR:
  - ALUOp = 001, ALUSrc = 0, EOp = 11, NPCOp = 01, PCWr = `zero`.
  - Next state: FETCH.
- The ALU, EOp and mux selects in EXE and BR are held stable for the whole cycle; datapath registers capture them at the next edge.

## Timing
- CPI: addu/subu/ori/lui = 4, lw = 5, sw = 4, beq = 3, j/jal/jr = 2, unknown = 2.
- Reset:
  - While `reset` is high, all write enables (PCWr, IRWr, RFWr, DMWr) are forced to 0, whatever the state.
  - On the first edge with `reset` high, state becomes FETCH.
  - The first FETCH write happens in the first cycle after `reset` falls.
- Reset asserted mid-instruction (for example in MEM of sw): DMWr is 0 in that cycle, and the instruction is abandoned with no partial write.
- `op`/`funct` are sampled only combinationally. They are not used in FETCH, because the IR updates at the end of that cycle.

## Configuration
- `MC_CTRL_JAL_EN` defined: j, jal and jr are decoded as described above.
- Not defined:
  - j, jal and jr decode as unknown: DCD goes to FETCH with no writes.
  - RegDst = 10, WDSel = 10 and NPCOp = 10/11 are never produced.

## Structure
- Package `mc_pkg` holds:
  - opcode and funct constants;
  - the state encodings;
  - EOp, ALUOp, RegDst, WDSel and NPCOp localparams (shared with the datapath muxes and the extender).
- One sub-module, `mc_decode`: combinational `op`/`funct` to one-hot instruction class (rtype_alu, ori, lui, lw, sw, beq, j, jal, jr, unknown). `mc_ctrl` contains the state register and per-state output logic.

## Test plan
- Reset, then addu (op 0, funct 100001): states 0,1,2,4,0. RFWr = 1 only in WB, with RegDst = 01 and WDSel = 00.
- lw (op 100011): 5 cycles. EOp = 00 and ALUSrc = 1 in EXE. RFWr = 1 with WDSel = 01 in WB. DMWr stays 0 throughout.
- beq (op 000100):
  - with `zero` = 1: BR shows PCWr = 1, NPCOp = 01, EOp = 11;
  - with `zero` = 0: PCWr = 0 in BR;
  - both cases return to FETCH after 3 cycles.
- jal (op 000011), with the macro: DCD gives PCWr = 1, NPCOp = 10, RFWr = 1, RegDst = 10, WDSel = 10, then FETCH. Without the macro: DCD gives no writes.
- sw, with `reset` pulsed high during MEM: DMWr = 0 in that cycle, state = FETCH on the next edge, and IRWr = 1 in the first post-reset cycle.
- Unknown op 111111 and lui (op 001111): unknown goes DCD to FETCH with all enables 0. lui gives EOp = 10 in EXE and RFWr = 1 with RegDst = 00 in WB.

Source files
------------

// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_pkg
//  Description : Shared encodings for the multi-cycle MIPS control unit:
//                opcodes, functs, FSM states, datapath mux/ALU/extender
//                select codes and the decoded instruction-class record.
//  Revision    : 1.0  initial release
// ============================================================================
package mc_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_ORI   = 6'b001101;
    localparam logic [5:0] C_OP_LUI   = 6'b001111;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_J     = 6'b000010;
    localparam logic [5:0] C_OP_JAL   = 6'b000011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] C_FN_ADDU  = 6'b100001;
    localparam logic [5:0] C_FN_SUBU  = 6'b100011;
    localparam logic [5:0] C_FN_JR    = 6'b001000;

    // Controller states; codes 6 and 7 are illegal
    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DCD   = 3'd1,
        S_EXE   = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_BR    = 3'd5
    } state_t;

    // Immediate extender modes
    localparam logic [1:0] C_EOP_SIGN     = 2'b00;
    localparam logic [1:0] C_EOP_ZERO     = 2'b01;
    localparam logic [1:0] C_EOP_LUI      = 2'b10;
    localparam logic [1:0] C_EOP_SIGN_SL2 = 2'b11;

    // ALU operations
    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_OR  = 3'b010;

    // ALU B-operand source
    localparam logic       C_ALUSRC_RT  = 1'b0;
    localparam logic       C_ALUSRC_EXT = 1'b1;

    // Register-file destination select
    localparam logic [1:0] C_RD_RT = 2'b00;
    localparam logic [1:0] C_RD_RD = 2'b01;
    localparam logic [1:0] C_RD_RA = 2'b10;

    // Register-file write-data select
    localparam logic [1:0] C_WD_ALU = 2'b00;
    localparam logic [1:0] C_WD_DM  = 2'b01;
    localparam logic [1:0] C_WD_PC  = 2'b10;

    // Next-PC select
    localparam logic [1:0] C_NPC_PC4 = 2'b00;
    localparam logic [1:0] C_NPC_BR  = 2'b01;
    localparam logic [1:0] C_NPC_J   = 2'b10;
    localparam logic [1:0] C_NPC_JR  = 2'b11;

    // One-hot instruction class produced by mc_decode
    typedef struct packed {
        logic rtype_alu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic unknown;
    } iclass_t;

endpackage : mc_pkg
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mc_decode
//  Description : Combinational op/funct to one-hot instruction class.
//                Jumps (j, jal, jr) are recognised only when MC_CTRL_JAL_EN
//                is defined; otherwise they fall into the unknown class.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_t    cls
);

    // Classify the instruction held in IR; anything unmatched is unknown
    always_comb begin
        cls = '0;
        case (op)
            C_OP_RTYPE: begin
                if (funct == C_FN_ADDU || funct == C_FN_SUBU) begin
                    cls.rtype_alu = 1'b1;
                end
`ifdef MC_CTRL_JAL_EN
                if (funct == C_FN_JR) begin
                    cls.jr = 1'b1;
                end
`endif
            end
            C_OP_ORI: cls.ori = 1'b1;
            C_OP_LUI: cls.lui = 1'b1;
            C_OP_LW:  cls.lw  = 1'b1;
            C_OP_SW:  cls.sw  = 1'b1;
            C_OP_BEQ: cls.beq = 1'b1;
`ifdef MC_CTRL_JAL_EN
            C_OP_J:   cls.j   = 1'b1;
            C_OP_JAL: cls.jal = 1'b1;
`endif
            default: ;
        endcase
        cls.unknown = ~(cls.rtype_alu | cls.ori | cls.lui | cls.lw | cls.sw |
                        cls.beq | cls.j | cls.jal | cls.jr);
    end

endmodule : mc_decode
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl
//  Description : Multi-cycle MIPS control unit. A state register sequences
//                FETCH/DCD/EXE/MEM/WB/BR; all datapath controls are
//                combinational from state, op, funct and zero.
//                Optional macro MC_CTRL_JAL_EN enables j/jal/jr decoding.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RFWr,
    output logic       DMWr,
    output logic [1:0] EOp,
    output logic [2:0] ALUOp,
    output logic       ALUSrc,
    output logic [1:0] RegDst,
    output logic [1:0] WDSel,
    output logic [1:0] NPCOp,
    output logic [2:0] state
);

    state_t  r_state;
    state_t  w_next;
    iclass_t w_cls;
    logic    w_pcwr;
    logic    w_irwr;
    logic    w_rfwr;
    logic    w_dmwr;

    mc_decode u_decode (
        .op    (op),
        .funct (funct),
        .cls   (w_cls)
    );

    // State register; reset (and any illegal code, via w_next) lands in FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Per-state next-state and datapath control decode
    always_comb begin
        w_next = S_FETCH;
        w_pcwr = 1'b0;
        w_irwr = 1'b0;
        w_rfwr = 1'b0;
        w_dmwr = 1'b0;
        EOp    = C_EOP_SIGN;
        ALUOp  = C_ALU_ADD;
        ALUSrc = C_ALUSRC_RT;
        RegDst = C_RD_RT;
        WDSel  = C_WD_ALU;
        NPCOp  = C_NPC_PC4;
        case (r_state)
            S_FETCH: begin
                // op/funct are stale here: IR loads at the end of this cycle
                w_irwr = 1'b1;
                w_pcwr = 1'b1;
                w_next = S_DCD;
            end
            S_DCD: begin
                if (w_cls.rtype_alu | w_cls.ori | w_cls.lui | w_cls.lw | w_cls.sw) begin
                    w_next = S_EXE;
                end else if (w_cls.beq) begin
                    w_next = S_BR;
                end else if (w_cls.unknown) begin
                    w_next = S_FETCH;
                end
                if (w_cls.j | w_cls.jal) begin
                    w_pcwr = 1'b1;
                    NPCOp  = C_NPC_J;
                end
                if (w_cls.jal) begin
                    // PC was already advanced in FETCH, so it holds the link value
                    w_rfwr = 1'b1;
                    RegDst = C_RD_RA;
                    WDSel  = C_WD_PC;
                end
                if (w_cls.jr) begin
                    w_pcwr = 1'b1;
                    NPCOp  = C_NPC_JR;
                end
            end
            S_EXE: begin
                if (w_cls.rtype_alu) begin
                    ALUOp  = (funct == C_FN_SUBU) ? C_ALU_SUB : C_ALU_ADD;
                    ALUSrc = C_ALUSRC_RT;
                end else if (w_cls.ori) begin
                    ALUOp  = C_ALU_OR;
                    ALUSrc = C_ALUSRC_EXT;
                    EOp    = C_EOP_ZERO;
                end else if (w_cls.lui) begin
                    ALUOp  = C_ALU_ADD;
                    ALUSrc = C_ALUSRC_EXT;
                    EOp    = C_EOP_LUI;
                end else if (w_cls.lw | w_cls.sw) begin
                    ALUOp  = C_ALU_ADD;
                    ALUSrc = C_ALUSRC_EXT;
                    EOp    = C_EOP_SIGN;
                end
                w_next = (w_cls.lw | w_cls.sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                w_dmwr = w_cls.sw;
                w_next = w_cls.lw ? S_WB : S_FETCH;
            end
            S_WB: begin
                w_rfwr = 1'b1;
                RegDst = w_cls.rtype_alu ? C_RD_RD : C_RD_RT;
                WDSel  = w_cls.lw ? C_WD_DM : C_WD_ALU;
                w_next = S_FETCH;
            end
            S_BR: begin
                ALUOp  = C_ALU_SUB;
                ALUSrc = C_ALUSRC_RT;
                EOp    = C_EOP_SIGN_SL2;
                NPCOp  = C_NPC_BR;
                w_pcwr = zero;
                w_next = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset suppresses every write so an abandoned instruction leaves no trace
    assign PCWr  = w_pcwr & ~reset;
    assign IRWr  = w_irwr & ~reset;
    assign RFWr  = w_rfwr & ~reset;
    assign DMWr  = w_dmwr & ~reset;
    assign state = r_state;

endmodule : mc_ctrl
`default_nettype wire
